// File: rtl/ram_master.sv
// rtl/ram_master.sv - request/response initiator sequencing a synchronous-read data RAM port
// Optional byte-enable read-modify-write path: define RAM_MASTER_RMW_EN.
module ram_master #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32,
  parameter int DOUT_W    = 48,
  parameter int MEM_DEPTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DOUT_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_CAP  = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4,
    RMW_CAP = 3'd5
  } state_t;

  state_t state;
  logic   in_range;

  assign req_ready = (state == IDLE);
  assign in_range  = (req_addr < ADDR_W'(MEM_DEPTH));

`ifdef RAM_MASTER_RMW_EN
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic              rmw_q;
  logic [DATA_W-1:0] merged;
  logic              unused_dout_hi;

  assign unused_dout_hi = ^ram_dout[DOUT_W-1:DATA_W];

  // Enabled bytes come from the request, the rest from the word just read back.
  always_comb begin
    merged = ram_dout[DATA_W-1:0];
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end
`else
  logic unused_dout_hi;

  assign unused_dout_hi = ^{ram_dout[DOUT_W-1:DATA_W], req_be};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
`ifdef RAM_MASTER_RMW_EN
      wdata_q   <= '0;
      be_q      <= '0;
      rmw_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (!in_range) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end else if (req_we) begin
`ifdef RAM_MASTER_RMW_EN
              if (req_be == 4'h0) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= '0;
                state     <= RESP;
              end else if (req_be != 4'hF) begin
                ram_addr <= req_addr;
                ram_we   <= 1'b0;
                wdata_q  <= req_wdata;
                be_q     <= req_be;
                rmw_q    <= 1'b1;
                state    <= RD_WAIT;
              end else begin
                ram_addr <= req_addr;
                ram_din  <= req_wdata;
                ram_we   <= 1'b1;
                state    <= WR;
              end
`else
              ram_addr <= req_addr;
              ram_din  <= req_wdata;
              ram_we   <= 1'b1;
              state    <= WR;
`endif
            end else begin
              ram_addr <= req_addr;
              ram_we   <= 1'b0;
`ifdef RAM_MASTER_RMW_EN
              rmw_q    <= 1'b0;
`endif
              state    <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
`ifdef RAM_MASTER_RMW_EN
          state <= rmw_q ? RMW_CAP : RD_CAP;
`else
          state <= RD_CAP;
`endif
        end
        RD_CAP: begin
          rsp_rdata <= ram_dout[DATA_W-1:0];
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
`ifdef RAM_MASTER_RMW_EN
        RMW_CAP: begin
          ram_din <= merged;
          ram_we  <= 1'b1;
          rmw_q   <= 1'b0;
          state   <= WR;
        end
`endif
        WR: begin
          ram_we    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
